// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU response path.
// Optional feature: UART_RESP_CHECKSUM_EN appends an XOR checksum byte to the packet.
`timescale 1ns/1ps
package uart_alu_pkg;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OP_ADD = 8'h10;
  localparam opcode_t OP_SUB = 8'h11;
  localparam opcode_t OP_MUL = 8'h12;
  localparam opcode_t OP_DIV = 8'h13;

  localparam int RESP_HDR_BYTES     = 4;
  localparam int RESP_PAYLOAD_BYTES = 4;
`ifdef UART_RESP_CHECKSUM_EN
  localparam int RESP_CSUM_BYTES    = 1;
`else
  localparam int RESP_CSUM_BYTES    = 0;
`endif
  localparam int RESP_PKT_BYTES     = RESP_HDR_BYTES + RESP_PAYLOAD_BYTES + RESP_CSUM_BYTES;
  localparam logic [15:0] RESP_LEN  = 16'(RESP_PKT_BYTES);

  typedef enum logic [1:0] {
    PKT_IDLE  = 2'd0,
    PKT_SEND  = 2'd1,
    PKT_DRAIN = 2'd2
  } pkt_state_e;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

`ifdef UART_RESP_CHECKSUM_EN
  function automatic logic [7:0] resp_checksum(input logic [7:0] op, input logic [31:0] res);
    return op ^ 8'h00 ^ RESP_LEN[7:0] ^ RESP_LEN[15:8] ^
           res[7:0] ^ res[15:8] ^ res[23:16] ^ res[31:24];
  endfunction
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; a new byte may be taken during the last stop-bit cycle so bytes run back-to-back.
`timescale 1ns/1ps
module uart_byte_tx
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 173
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last_s;

  assign baud_last_s  = (baud_q == BAUD_LAST);
  assign done_o       = (state_q == SER_STOP) && baud_last_s;
  assign byte_ready_o = (state_q == SER_IDLE) || done_o;
  assign tx_o         = tx_q;

  // Next-state logic: bit timing, shift register and line level
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if ((state_q == SER_IDLE) || baud_last_s) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + CW'(1);
    end
    case (state_q)
      SER_IDLE: begin
        if (byte_valid_i) begin
          state_d = SER_START;
          shift_d = byte_i;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      SER_START: begin
        if (baud_last_s) begin
          state_d = SER_DATA;
          tx_d    = shift_q[0];
        end else begin
          state_d = SER_START;
        end
      end
      SER_DATA: begin
        if (baud_last_s && (bit_q == 3'd7)) begin
          state_d = SER_STOP;
          tx_d    = 1'b1;
        end else if (baud_last_s) begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[1];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          state_d = SER_DATA;
        end
      end
      SER_STOP: begin
        if (baud_last_s && byte_valid_i) begin
          state_d = SER_START;
          shift_d = byte_i;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
        end else if (baud_last_s) begin
          state_d = SER_IDLE;
          tx_d    = 1'b1;
        end else begin
          state_d = SER_STOP;
        end
      end
      default: begin
        state_d = SER_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serializer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_alu_resp_tx.sv
// Frames one ALU result into a fixed byte packet and sends it 8N1 on tx_o.
// Optional feature: UART_RESP_CHECKSUM_EN adds a trailing XOR checksum byte.
`timescale 1ns/1ps
module uart_alu_resp_tx
  import uart_alu_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [7:0]  opcode_i,
  input  logic [31:0] result_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [3:0] LAST_IDX = 4'(RESP_PKT_BYTES - 1);

  pkt_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        accept_s;
  logic        byte_valid_s;
  logic        byte_ready_s;
  logic        byte_fire_s;
  logic        ser_done_s;
  logic [7:0]  byte_s;

  assign accept_s     = valid_i && ready_q;
  assign byte_valid_s = (state_q == PKT_SEND);
  assign byte_fire_s  = byte_valid_s && byte_ready_s;
  assign ready_o      = ready_q;
  assign busy_o       = busy_q;

  // Packet sequencing; DRAIN waits out the final byte's stop bit before re-arming
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opcode_d = opcode_q;
    result_d = result_q;
    case (state_q)
      PKT_IDLE: begin
        if (accept_s) begin
          state_d  = PKT_SEND;
          idx_d    = 4'd0;
          opcode_d = opcode_i;
          result_d = result_i;
        end else begin
          state_d  = PKT_IDLE;
        end
      end
      PKT_SEND: begin
        if (byte_fire_s && (idx_q == LAST_IDX)) begin
          state_d = PKT_DRAIN;
          idx_d   = 4'd0;
        end else if (byte_fire_s) begin
          idx_d   = idx_q + 4'd1;
        end else begin
          state_d = PKT_SEND;
        end
      end
      PKT_DRAIN: begin
        if (ser_done_s) begin
          state_d = PKT_IDLE;
        end else begin
          state_d = PKT_DRAIN;
        end
      end
      default: begin
        state_d = PKT_IDLE;
        idx_d   = 4'd0;
      end
    endcase
    ready_d = (state_d == PKT_IDLE);
    busy_d  = !ready_d;
  end

  // Byte selection for the current packet index
  always_comb begin
    byte_s = 8'h00;
    case (idx_q)
      4'd0:    byte_s = opcode_q;
      4'd1:    byte_s = 8'h00;
      4'd2:    byte_s = RESP_LEN[7:0];
      4'd3:    byte_s = RESP_LEN[15:8];
      4'd4:    byte_s = result_q[7:0];
      4'd5:    byte_s = result_q[15:8];
      4'd6:    byte_s = result_q[23:16];
      4'd7:    byte_s = result_q[31:24];
`ifdef UART_RESP_CHECKSUM_EN
      4'd8:    byte_s = resp_checksum(opcode_q, result_q);
`endif
      default: byte_s = 8'h00;
    endcase
  end

  // Packet registers and handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PKT_IDLE;
      idx_q    <= 4'd0;
      opcode_q <= 8'h00;
      result_q <= 32'h0000_0000;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (byte_valid_s),
    .byte_i       (byte_s),
    .byte_ready_o (byte_ready_s),
    .done_o       (ser_done_s),
    .tx_o         (tx_o)
  );

endmodule
